// File: rtl/adpll_arb_pkg.sv
// Shared types and constants for the ADPLL DCO tuning-port arbiter.
// Holds the arbiter state enum, requester count and requester indices.
package adpll_arb_pkg;

  localparam int N_REQ = 5;

  localparam logic [2:0] CAL = 3'd0;
  localparam logic [2:0] ACQ = 3'd1;
  localparam logic [2:0] TRK = 3'd2;
  localparam logic [2:0] SDM = 3'd3;
  localparam logic [2:0] SW  = 3'd4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_OWN  = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  // Next requester index, wrapping SW back to CAL.
  function automatic logic [2:0] inc5(input logic [2:0] i);
    return (i == SW) ? CAL : i + 3'd1;
  endfunction

endpackage

// File: rtl/rr_pick5.sv
// Combinational round-robin picker over five requesters.
// Ports: i_req, i_ptr (search start) -> o_onehot, o_idx, o_any.
module rr_pick5
  import adpll_arb_pkg::*;
(
  input  logic [N_REQ-1:0] i_req,
  input  logic [2:0]       i_ptr,
  output logic [N_REQ-1:0] o_onehot,
  output logic [2:0]       o_idx,
  output logic             o_any
);

  logic [2:0] w_c;
  logic       w_hit;

  // Walk upward from i_ptr; first set bit wins.
  always_comb begin
    o_idx = '0;
    w_hit = 1'b0;
    w_c   = i_ptr;
    for (int k = 0; k < N_REQ; k++) begin
      if (!w_hit && i_req[w_c]) begin
        o_idx = w_c;
        w_hit = 1'b1;
      end
      w_c = inc5(w_c);
    end
  end

  assign o_any    = |i_req;
  assign o_onehot = o_any ? (5'b00001 << o_idx) : '0;

endmodule

// File: rtl/dco_tune_arbiter.sv
// Round-robin owner arbiter for the shared DCO tuning-word write port.
// Ports: clk, rst_n, req, wr, wdata -> gnt, dco_we, dco_wdata, busy, timeout.
module dco_tune_arbiter #(
  parameter int N_REQ    = 5,
  parameter int DW       = 8,
  parameter int MAX_HOLD = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ-1:0]    wr,
  input  logic [N_REQ*DW-1:0] wdata,
  output logic [N_REQ-1:0]    gnt,
  output logic                dco_we,
  output logic [DW-1:0]       dco_wdata,
  output logic                busy,
  output logic                timeout
);
  import adpll_arb_pkg::*;

  localparam int HW = $clog2(MAX_HOLD);
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

  state_t           r_state, w_state;
  logic [2:0]       r_owner, w_owner;
  logic [2:0]       r_ptr, w_ptr;
  logic [HW-1:0]    r_hold, w_hold;
  logic [N_REQ-1:0] r_gnt, w_gnt;
  logic             r_we, w_we;
  logic [DW-1:0]    r_wdata, w_wdata;
  logic             r_to, w_to;
  logic [N_REQ-1:0] w_pick_oh;
  logic [2:0]       w_pick_idx;
  logic             w_pick_any;
  logic             w_last;

  rr_pick5 u_pick (
    .i_req    (req),
    .i_ptr    (r_ptr),
    .o_onehot (w_pick_oh),
    .o_idx    (w_pick_idx),
    .o_any    (w_pick_any)
  );

  assign w_last = (r_hold == HOLD_LAST);

  always_comb begin
    w_state = r_state;
    w_owner = r_owner;
    w_ptr   = r_ptr;
    w_hold  = r_hold;
    w_gnt   = '0;
    w_we    = 1'b0;
    w_wdata = r_wdata;
    w_to    = 1'b0;
    unique case (r_state)
      S_OWN: begin
        // Owner write is honoured even on its release cycle.
        if (wr[r_owner]) begin
          w_we    = 1'b1;
          w_wdata = wdata[r_owner*DW +: DW];
        end
        if (w_last || !req[r_owner]) begin
          w_state = S_GAP;
          w_ptr   = inc5(r_owner);
          w_to    = w_last;
        end else begin
          w_gnt  = r_gnt;
          w_hold = r_hold + 1'b1;
        end
      end
      default: begin
        if (w_pick_any) begin
          w_state = S_OWN;
          w_owner = w_pick_idx;
          w_gnt   = w_pick_oh;
          w_hold  = '0;
        end else begin
          w_state = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_owner <= '0;
      r_ptr   <= '0;
      r_hold  <= '0;
      r_gnt   <= '0;
      r_we    <= 1'b0;
      r_wdata <= '0;
      r_to    <= 1'b0;
    end else begin
      r_state <= w_state;
      r_owner <= w_owner;
      r_ptr   <= w_ptr;
      r_hold  <= w_hold;
      r_gnt   <= w_gnt;
      r_we    <= w_we;
      r_wdata <= w_wdata;
      r_to    <= w_to;
    end
  end

  assign gnt       = r_gnt;
  assign dco_we    = r_we;
  assign dco_wdata = r_wdata;
  assign timeout   = r_to;
  assign busy      = (r_state == S_OWN);

endmodule

// File: tb/tb_dco_tune_arbiter.sv
// Scoreboard bench for dco_tune_arbiter with a cycle-level reference model.
// Directed scenarios followed by randomized request/write traffic.
module tb_dco_tune_arbiter;
  import adpll_arb_pkg::*;

  localparam int NR = 5;
  localparam int DWT = 8;
  localparam int MH = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [NR-1:0]  req = '0;
  logic [NR-1:0]  wr = '0;
  logic [NR*DWT-1:0] wdata = '0;
  logic [NR-1:0]  gnt;
  logic           dco_we;
  logic [DWT-1:0] dco_wdata;
  logic           busy;
  logic           timeout;

  dco_tune_arbiter #(.N_REQ(NR), .DW(DWT), .MAX_HOLD(MH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .wr        (wr),
    .wdata     (wdata),
    .gnt       (gnt),
    .dco_we    (dco_we),
    .dco_wdata (dco_wdata),
    .busy      (busy),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NR-1:0]  gnt;
    logic           we;
    logic [DWT-1:0] wd;
    logic           busy;
    logic           to;
  } exp_t;

  exp_t q[$];
  int n_checks = 0;
  int n_pass = 0;

  // Reference model: 0 idle, 1 owning, 2 dead cycle.
  int m_st = 0;
  int m_own = 0;
  int m_ptr = 0;
  int m_hold = 0;
  logic [DWT-1:0] m_wd = '0;

  task automatic chk(input string nm, input logic [39:0] act,
                     input logic [39:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  task automatic model_reset();
    m_st = 0; m_own = 0; m_ptr = 0; m_hold = 0; m_wd = '0;
  endtask

  task automatic model_step();
    exp_t e;
    int w;
    int idx;
    logic we;
    logic to;
    e = '0;
    if (!rst_n) begin
      model_reset();
      q.push_back(e);
      return;
    end
    we = 1'b0;
    to = 1'b0;
    if (m_st == 1) begin
      if (wr[m_own]) begin
        we = 1'b1;
        m_wd = wdata[m_own*DWT +: DWT];
      end
      if (m_hold == MH - 1 || !req[m_own]) begin
        to = (m_hold == MH - 1);
        m_ptr = (m_own + 1) % NR;
        m_st = 2;
      end else begin
        m_hold++;
      end
    end else begin
      w = -1;
      for (int k = 0; k < NR; k++) begin
        idx = (m_ptr + k) % NR;
        if (w < 0 && req[idx]) w = idx;
      end
      if (w >= 0) begin
        m_st = 1; m_own = w; m_hold = 0;
      end else begin
        m_st = 0;
      end
    end
    e.gnt  = (m_st == 1) ? NR'(1 << m_own) : '0;
    e.we   = we;
    e.wd   = m_wd;
    e.busy = (m_st == 1);
    e.to   = to;
    q.push_back(e);
  endtask

  initial forever begin
    @(negedge rst_n);
    model_reset();
  end

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Monitor: every cycle the DUT presents a registered output bundle.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (q.size() > 0) begin
      e = q.pop_front();
      if (!rst_n) e = '0;
      chk("sb_gnt", 40'(gnt), 40'(e.gnt));
      chk("sb_we", 40'(dco_we), 40'(e.we));
      chk("sb_wdata", 40'(dco_wdata), 40'(e.wd));
      chk("sb_busy", 40'(busy), 40'(e.busy));
      chk("sb_timeout", 40'(timeout), 40'(e.to));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1);
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req = '0;
    wr = '0;
    cyc();
    cyc();
    rst_n = 1'b1;
  endtask

  initial begin
    int order[$];
    int exp_order[6];
    logic [NR-1:0] prev;
    int drops;
    int tos;
    exp_order = '{int'(CAL), int'(ACQ), int'(TRK), int'(SDM), int'(SW), int'(CAL)};

    // Reset with a pending request.
    req = 5'b00100;
    cyc();
    #1;
    chk("rst_gnt", 40'(gnt), 40'd0);
    chk("rst_we", 40'(dco_we), 40'd0);
    chk("rst_wdata", 40'(dco_wdata), 40'd0);
    chk("rst_busy", 40'(busy), 40'd0);
    chk("rst_to", 40'(timeout), 40'd0);
    cyc();
    rst_n = 1'b1;
    cyc();
    chk("first_gnt", 40'(gnt), 40'(5'b00100));
    chk("first_busy", 40'(busy), 40'd1);

    // All requesting: round-robin order with forced releases.
    do_reset();
    req = 5'b11111;
    prev = '0;
    drops = 0;
    tos = 0;
    for (int i = 0; i < 32; i++) begin
      cyc();
      if (gnt != 0 && prev == 0)
        for (int b = 0; b < NR; b++) if (gnt[b]) order.push_back(b);
      if (gnt == 0 && prev != 0) drops++;
      if (timeout) tos++;
      prev = gnt;
    end
    chk("rr_count", 40'(order.size() >= 6), 40'd1);
    for (int i = 0; i < 6 && i < order.size(); i++)
      chk($sformatf("rr_order%0d", i), 40'(order[i]), 40'(exp_order[i]));
    chk("rr_timeouts", 40'(tos), 40'(drops));

    // Owner write beside a non-owner write.
    do_reset();
    req = 5'b00010;
    cyc();
    chk("w_gnt", 40'(gnt), 40'(5'b00010));
    wr = 5'b01010;
    wdata = 40'h00_FF_00_5A_00;
    cyc();
    chk("w_we", 40'(dco_we), 40'd1);
    chk("w_data", 40'(dco_wdata), 40'h5A);
    wr = '0;
    req = '0;
    cyc();
    cyc();

    // Drop and write in the same cycle, next owner waiting.
    req = 5'b00100;
    cyc();
    chk("dw_gnt", 40'(gnt), 40'(5'b00100));
    req = 5'b01000;
    wr = 5'b00100;
    wdata = 40'h00_00_33_00_00;
    cyc();
    chk("dw_we", 40'(dco_we), 40'd1);
    chk("dw_data", 40'(dco_wdata), 40'h33);
    chk("dw_gnt0", 40'(gnt), 40'd0);
    wr = '0;
    cyc();
    chk("dw_next", 40'(gnt), 40'(5'b01000));

    // Asynchronous reset while requester 3 owns.
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_gnt", 40'(gnt), 40'd0);
    chk("ar_we", 40'(dco_we), 40'd0);
    chk("ar_to", 40'(timeout), 40'd0);
    chk("ar_busy", 40'(busy), 40'd0);
    cyc();
    req = 5'b11000;
    cyc();
    rst_n = 1'b1;
    cyc();
    chk("ar_regnt", 40'(gnt), 40'(5'b01000));
    req = '0;
    cyc();
    cyc();

    // Lone owner 0 releases, idles, then re-requests.
    do_reset();
    req = 5'b00001;
    cyc();
    chk("lo_gnt", 40'(gnt), 40'(5'b00001));
    req = '0;
    cyc();
    chk("lo_gap", 40'(gnt), 40'd0);
    cyc();
    chk("lo_idle", 40'(busy), 40'd0);
    req = 5'b00001;
    cyc();
    chk("lo_regnt", 40'(gnt), 40'(5'b00001));

    // Randomized traffic.
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 3) == 0) req = NR'($urandom_range(0, 31));
      wr = NR'($urandom_range(0, 31));
      wdata = {8'($urandom), $urandom};
      cyc();
    end
    req = '0;
    wr = '0;
    cyc();
    cyc();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dco_tune_arbiter.md
# dco_tune_arbiter

Round-robin arbiter that shares the single DCO tuning-word write port of the ADPLL among five requesters: PVT/coarse calibration, frequency acquisition, fine tracking, dither/SDM and software override. It grants one owner at a time, forwards that owner's writes to the DCO control register with one register stage, and forces release after a bounded hold. It sits between the loop-control blocks and the DCO bank decoder.

## Interface
- `N_REQ`, 5: number of requesters; fixed at 5, other values unsupported.
- `DW`, 8: tuning-word width.
- `MAX_HOLD`, 16: maximum consecutive cycles in ownership before forced release; legal range 2..255.

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req`  in  N_REQ  per-requester ownership request; level, held while ownership is wanted.
- `wr`  in  N_REQ  per-requester write strobe; honoured only from the current owner.
- `wdata`  in  N_REQ*DW  concatenated tuning words; requester i uses bits [i*DW +: DW].
- `gnt`  out  N_REQ  one-hot (or zero) grant, registered.
- `dco_we`  out  1  write enable to the DCO control register, registered.
- `dco_wdata`  out  DW  tuning word accompanying `dco_we`, registered.
- `busy`  out  1  high while any grant is held.
- `timeout`  out  1  one-cycle pulse when a forced release occurs.

## Operation
- States:
  - IDLE: no grant.
  - OWN: one grant held.
  - GAP: one dead cycle after any release.
- IDLE → OWN when any `req` bit is sampled high. Winner is the first set bit at or after `ptr`, searching upward modulo 5.
- OWN → GAP when any of the following holds:
  - the owner's `req` is sampled low;
  - the hold counter reaches MAX_HOLD−1, which also pulses `timeout`.
- On OWN → GAP, `ptr` becomes owner+1 modulo 5.
- GAP → OWN if any `req` is high (same round-robin pick with the updated `ptr`); otherwise GAP → IDLE.
- Hold counter: ceil(log2 MAX_HOLD) bits, cleared on entry to OWN, incremented each OWN cycle.
- Writes:
  - In OWN, an owner `wr` sampled high causes `dco_we`=1 the next cycle, with `dco_wdata` equal to the owner's slice.
  - Non-owner `wr` is ignored.
  - `dco_wdata` holds its last value when `dco_we`=0.
- `busy` = OWN state.
- `gnt` is never multi-hot and is never asserted in GAP.

## Timing
- Reset values:
  - `gnt`=0, `dco_we`=0, `dco_wdata`=0, `busy`=0, `timeout`=0;
  - state IDLE, `ptr`=0, hold counter 0.
- Request → grant latency is 1 cycle: `req` high at edge t gives `gnt` high after edge t.
- Write latency is 1 cycle from the sampled owner `wr` to `dco_we`.
- Release latency is 1 cycle from the sampled `req` low to `gnt` low. The GAP cycle follows, so there is at least one zero-grant cycle between owners.
- Owner `wr` and `req` low in the same cycle: the write is honoured, and `dco_we` pulses in the cycle that `gnt` drops.
- Forced release: a write on the final OWN cycle is honoured, and `timeout` pulses in the same cycle as the `gnt` drop.
- A forced-out requester still holding `req` re-enters arbitration in GAP at the lowest round-robin priority.
- Asynchronous reset mid-ownership immediately clears `gnt`, `dco_we` and `timeout`. `ptr` returns to 0.
- Single requester continuously high: OWN for MAX_HOLD cycles, 1 GAP cycle, then re-granted.

## Structure
- Shared package `adpll_arb_pkg` holds:
  - the state enum (IDLE, OWN, GAP);
  - `N_REQ`;
  - requester index constants (CAL=0, ACQ=1, TRK=2, SDM=3, SW=4).
- The natural sub-module is `rr_pick5`: combinational round-robin picker taking `req[4:0]` and `ptr[2:0]` and returning a one-hot winner and its index.
- The top level contains the FSM, hold counter, write mux and output registers.

## Test plan
- Reset with `req`=5'b00100 asserted → all outputs 0 during reset. After release: `gnt`=5'b00100 one cycle later, `busy`=1.
- `req`=5'b11111 held high, MAX_HOLD=4 → grants in order 0,1,2,3,4,0. Each grant lasts 4 cycles followed by 1 GAP cycle, and `timeout` pulses on every drop.
- Owner 1 with `wr`[1]=1, `wdata` slice 0x5A; simultaneously `wr`[3]=1 with slice 0xFF → `dco_we`=1, `dco_wdata`=0x5A next cycle; 0xFF never appears.
- Owner 2 drops `req` and pulses `wr` with 0x33 in the same cycle → `dco_we`=1 with 0x33 while `gnt` goes 0, then one GAP cycle, then the next requester is granted.
- `rst_n` pulsed low mid-ownership of requester 3 → `gnt`, `dco_we` and `timeout` clear asynchronously. After reset, `req`=5'b11000 grants requester 3 (`ptr`=0).
- Owner 0 drops `req` with no other requester active → GAP, then IDLE. A new `req`[0] two cycles later is granted after 1 cycle (`ptr`=1, wraps to 0).
